// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide both take one bit per cycle.
// Operands are reduced to magnitudes at accept, and signs are reapplied in FIX.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo writes allowed
// RUN   | WIDTH iterations of shift-add or restoring divide
// FIX   | sign correction, HI/LO update, done pulse
module mdu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand |a| or divisor |b|
  logic [WIDTH-1:0]   a_raw_q, a_raw_d; // original dividend for divide-by-zero
  logic               neg_q, neg_d;     // result sign differs (signed ops only)
  logic               rneg_q, rneg_d;   // dividend was negative (signed ops only)
  logic               bzero_q, bzero_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_sh, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem;

  // Operand magnitudes; only signed ops (op[0]=1) negate a negative operand.
  assign a_abs = (op[0] && a[WIDTH-1]) ? -a : a;
  assign b_abs = (op[0] && b[WIDTH-1]) ? -b : b;

  // Shift-add step: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step: acc = {partial remainder, dividend bits / quotient bits}.
  assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign div_ge   = (div_sh >= {1'b0, opnd_q});
  assign div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};

  assign prod_fix = (op_q == 2'b01 && neg_q) ? -acc_q : acc_q;
  assign quo      = acc_q[WIDTH-1:0];
  assign rem      = acc_q[2*WIDTH-1:WIDTH];

  // Next-state and datapath update for all registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    a_raw_d = a_raw_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    bzero_d = bzero_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          busy_d  = 1'b1;
          op_d    = op;
          a_raw_d = a;
          neg_d   = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d  = op[0] & a[WIDTH-1];
          bzero_d = (b == '0);
          if (op[1]) begin
            opnd_d = b_abs;
            acc_d  = {{WIDTH{1'b0}}, a_abs};
          end else begin
            opnd_d = a_abs;
            acc_d  = {{WIDTH{1'b0}}, b_abs};
          end
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_RUN: begin
        acc_d = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        cnt_d   = '0;
        if (!op_q[1]) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (bzero_q) begin
          lo_d  = '1;
          hi_d  = a_raw_q;
          dbz_d = 1'b1;
        end else begin
          lo_d = neg_q  ? -quo : quo;
          hi_d = rneg_q ? -rem : rem;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opnd_q  <= '0;
      a_raw_q <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      a_raw_q <= a_raw_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      bzero_q <= bzero_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: scoreboard of expected HI/LO results from an
// arithmetic reference model, directed corner cases plus random ops.
module tb_mdu_iterative;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  mdu_iterative #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  logic done_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the operands.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    logic [63:0] up;
    longint      sp;
    int          sx, sy;
    sx = x;
    sy = y;
    e.dbz = 1'b0;
    case (o)
      2'd0: begin
        up = {32'b0, x} * {32'b0, y};
        e.hi = up[63:32];
        e.lo = up[31:0];
      end
      2'd1: begin
        sp = longint'(sx) * longint'(sy);
        up = sp;
        e.hi = up[63:32];
        e.lo = up[31:0];
      end
      2'd2: begin
        if (y == 0) begin
          e.lo = '1; e.hi = x; e.dbz = 1'b1;
        end else begin
          e.lo = x / y; e.hi = x % y;
        end
      end
      default: begin
        if (y == 0) begin
          e.lo = '1; e.hi = x; e.dbz = 1'b1;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = '0;
        end else begin
          e.lo = sx / sy; e.hi = sx % sy;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever a result is presented.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (done && done_prev) begin
        tests++; fails++;
        $display("FAIL done_width: done high two cycles in a row");
      end
      if (div_by_zero && !done) begin
        tests++; fails++;
        $display("FAIL dbz_without_done: div_by_zero=1 done=0");
      end
      if (done) begin
        if (sbq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done with hi=%h lo=%h, expected none", hi, lo);
        end else begin
          e = sbq.pop_front();
          check("result_hi", 64'(hi), 64'(e.hi));
          check("result_lo", 64'(lo), 64'(e.lo));
          check("result_dbz", 64'(div_by_zero), 64'(e.dbz));
        end
      end
    end
    done_prev = done;
  end

  // Called at a negedge; waits for idle, presents start for one cycle.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++; fails++;
      $display("FAIL issue_timeout: busy still 1, expected 0");
    end
    op = o; a = x; b = y; start = 1'b1;
    if (push) sbq.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++; fails++;
      $display("FAIL idle_timeout: busy still 1, expected 0");
    end
  endtask

  initial begin
    int           cnt;
    int           n;
    logic [W-1:0] hold_hi;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = '0; a = '0; b = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dbz", 64'(div_by_zero), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // multu max*max, busy length and HI/LO hold during RUN
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    cnt = 0; n = 0;
    while (busy && n < 100) begin
      cnt++;
      if (cnt == 16) begin
        check("hold_hi_run", 64'(hi), 64'd0);
        check("hold_lo_run", 64'(lo), 64'd0);
      end
      @(negedge clk);
      n++;
    end
    check("busy_cycles", 64'(cnt), 64'd33);

    // signed mult and div, back-to-back
    issue(2'd1, 32'hFFFF_FFFD, 32'd5, 1'b1);
    issue(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    // divide by zero, then signed overflow
    issue(2'd2, 32'd100, 32'd0, 1'b1);
    issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle();

    // start and mthi during RUN are ignored
    issue(2'd0, 32'd6, 32'd7, 1'b1);
    hold_hi = hi;
    repeat (9) @(negedge clk);
    start = 1'b1; op = 2'd2; a = 32'd50; b = 32'd3; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    check("ignored_start_busy", 64'(busy), 64'd1);
    check("ignored_mthi", 64'(hi), 64'(hold_hi));
    wait_idle();

    // reset mid divide aborts without done
    issue(2'd2, 32'd1000, 32'd7, 1'b0);
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    repeat (50) @(negedge clk);

    // mthi in idle, then mtlo colliding with start
    hi_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_idle", 64'(hi), 64'h1234);
    op = 2'd0; a = 32'd3; b = 32'd4; start = 1'b1; lo_we = 1'b1; wdata = 32'h0000_5555;
    sbq.push_back(model(2'd0, 32'd3, 32'd4));
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    check("mtlo_dropped", 64'(lo), 64'd0);
    check("mtlo_hi_kept", 64'(hi), 64'h1234);
    check("start_wins_busy", 64'(busy), 64'd1);
    wait_idle();

    // explicit back-to-back multu: second accept in the done cycle
    issue(2'd0, 32'd123, 32'd456, 1'b1);
    wait_idle();
    check("b2b_done_at_accept", 64'(done), 64'd1);
    issue(2'd0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);

    // random ops with corner operands mixed in
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      issue(ro, ra, rb, 1'b1);
    end
    wait_idle();
    @(negedge clk);
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
